// File: rtl/punc_run_control.sv
// Run/halt/step sequencer for the PUnC LC3 core: gates the core with cpu_en and
// stops it only at instruction boundaries on host command, step count, breakpoint or HALT trap.
module punc_run_control #(
    parameter int NUM_BP        = 4,
    parameter int BP_IDX_W      = 2,
    parameter int CNT_W         = 8,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd_op,
    input  logic [CNT_W-1:0]    cmd_count,
    input  logic                instr_retire,
    input  logic [15:0]         ir,
    input  logic [15:0]         pc_next,
    input  logic                bp_wr_en,
    input  logic [BP_IDX_W-1:0] bp_wr_idx,
    input  logic [15:0]         bp_wr_addr,
    input  logic                bp_wr_valid,
    output logic                cpu_en,
    output logic                halted,
    output logic [1:0]          halt_cause,
    output logic [BP_IDX_W-1:0] bp_hit_idx,
    output logic                cmd_err,
    output logic [15:0]         retire_count
);

    typedef enum logic [1:0] {
        S_HALTED   = 2'd0,
        S_RUNNING  = 2'd1,
        S_STEPPING = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    localparam logic [1:0] OP_CLR_CNT = 2'b00;
    localparam logic [1:0] OP_RUN     = 2'b01;
    localparam logic [1:0] OP_HALT    = 2'b10;
    localparam logic [1:0] OP_STEP    = 2'b11;

    localparam logic [1:0] CAUSE_RESET = 2'b00;
    localparam logic [1:0] CAUSE_HOST  = 2'b01;
    localparam logic [1:0] CAUSE_BP    = 2'b10;
    localparam logic [1:0] CAUSE_TRAP  = 2'b11;

    localparam logic [15:0] TRAP_HALT = 16'hF025;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic                  skip_bp_q, skip_bp_d;
    logic [1:0]            halt_cause_q, halt_cause_d;
    logic [BP_IDX_W-1:0]   bp_hit_idx_q, bp_hit_idx_d;
    logic                  cmd_err_q, cmd_err_d;
    logic [15:0]           retire_count_q, retire_count_d;

    logic [15:0]           bp_addr [NUM_BP];
    logic [NUM_BP-1:0]     bp_valid;

    logic                  counting;
    logic                  halt_fire;
    logic                  bp_any;
    logic [BP_IDX_W-1:0]   bp_low;

    assign cpu_en       = (state_q != S_HALTED);
    assign halted       = ~cpu_en;
    assign halt_cause   = halt_cause_q;
    assign bp_hit_idx   = bp_hit_idx_q;
    assign cmd_err      = cmd_err_q;
    assign retire_count = retire_count_q;
    assign counting     = instr_retire & cpu_en;

    // Downward scan so the lowest matching entry is the one left standing.
    always_comb begin
        bp_any = 1'b0;
        bp_low = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_valid[i] && (bp_addr[i] == pc_next)) begin
                bp_any = 1'b1;
                bp_low = BP_IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        skip_bp_d      = skip_bp_q;
        halt_cause_d   = halt_cause_q;
        bp_hit_idx_d   = bp_hit_idx_q;
        cmd_err_d      = 1'b0;
        retire_count_d = retire_count_q;
        halt_fire      = 1'b0;

        if (counting) begin
            retire_count_d = retire_count_q + 16'd1;
            skip_bp_d      = 1'b0;
            if (state_q == S_STEPPING)
                remaining_d = remaining_q - CNT_W'(1);

            if (ir == TRAP_HALT) begin
                halt_fire    = 1'b1;
                halt_cause_d = CAUSE_TRAP;
            end else if (bp_any && !skip_bp_q) begin
                halt_fire    = 1'b1;
                halt_cause_d = CAUSE_BP;
                bp_hit_idx_d = bp_low;
            end else if ((state_q == S_STEPPING) && (remaining_q == CNT_W'(1))) begin
                halt_fire    = 1'b1;
                halt_cause_d = CAUSE_BP;
            end else if (state_q == S_DRAIN) begin
                halt_fire    = 1'b1;
                halt_cause_d = CAUSE_HOST;
            end
        end

        // A halting retire swallows any coincident state-changing command silently.
        if (halt_fire) begin
            state_d = S_HALTED;
        end else if (cmd_valid) begin
            case (cmd_op)
                OP_RUN: begin
                    if (state_q == S_HALTED) begin
                        state_d   = S_RUNNING;
                        skip_bp_d = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                OP_STEP: begin
                    if (state_q == S_HALTED) begin
                        state_d     = S_STEPPING;
                        remaining_d = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                        skip_bp_d   = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                OP_HALT: begin
                    if ((state_q == S_RUNNING) || (state_q == S_STEPPING))
                        state_d = S_DRAIN;
                    else
                        cmd_err_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (cmd_valid && (cmd_op == OP_CLR_CNT))
            retire_count_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= START_RUNNING ? S_RUNNING : S_HALTED;
            remaining_q    <= '0;
            skip_bp_q      <= 1'b0;
            halt_cause_q   <= CAUSE_RESET;
            bp_hit_idx_q   <= '0;
            cmd_err_q      <= 1'b0;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            skip_bp_q      <= skip_bp_d;
            halt_cause_q   <= halt_cause_d;
            bp_hit_idx_q   <= bp_hit_idx_d;
            cmd_err_q      <= cmd_err_d;
            retire_count_q <= retire_count_d;
        end
    end

    // Table updates land at the edge, so a same-cycle retire still sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_valid <= '0;
            for (int i = 0; i < NUM_BP; i++)
                bp_addr[i] <= '0;
        end else if (bp_wr_en) begin
            bp_valid[bp_wr_idx] <= bp_wr_valid;
            bp_addr[bp_wr_idx]  <= bp_wr_addr;
        end
    end

endmodule

// File: tb/tb_punc_run_control.sv
// Self-checking bench for punc_run_control: directed scenarios followed by
// randomized traffic checked against a behavioural model of the run/halt rules.
module tb_punc_run_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_count;
    logic        instr_retire;
    logic [15:0] ir;
    logic [15:0] pc_next;
    logic        bp_wr_en;
    logic [1:0]  bp_wr_idx;
    logic [15:0] bp_wr_addr;
    logic        bp_wr_valid;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [1:0]  bp_hit_idx;
    logic        cmd_err;
    logic [15:0] retire_count;

    int checks = 0;
    int errors = 0;

    // Reference model: core is either stopped or going; going may carry a step budget or a pending host stop.
    bit        m_halted;
    bit        m_step_mode;
    bit        m_drain;
    bit        m_skip;
    bit        m_err;
    int        m_left;
    bit [1:0]  m_cause;
    bit [1:0]  m_hit;
    bit [15:0] m_count;
    bit        m_bp_v [4];
    bit [15:0] m_bp_a [4];

    always #5 clk = ~clk;

    punc_run_control #(
        .NUM_BP(4), .BP_IDX_W(2), .CNT_W(8), .START_RUNNING(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_count(cmd_count),
        .instr_retire(instr_retire), .ir(ir), .pc_next(pc_next),
        .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid),
        .cpu_en(cpu_en), .halted(halted), .halt_cause(halt_cause), .bp_hit_idx(bp_hit_idx),
        .cmd_err(cmd_err), .retire_count(retire_count)
    );

    task automatic model_reset();
        m_halted = 1'b0; m_step_mode = 1'b0; m_drain = 1'b0; m_skip = 1'b0; m_err = 1'b0;
        m_left = 0; m_cause = 2'd0; m_hit = 2'd0; m_count = 16'd0;
        for (int i = 0; i < 4; i++) begin
            m_bp_v[i] = 1'b0;
            m_bp_a[i] = 16'd0;
        end
    endtask

    task automatic model_step();
        bit counting;
        bit stop;
        int hit;
        counting = instr_retire && !m_halted;
        stop = 1'b0;
        m_err = 1'b0;
        if (counting) begin
            hit = -1;
            for (int i = 3; i >= 0; i--)
                if (m_bp_v[i] && m_bp_a[i] == pc_next) hit = i;
            if (ir == 16'hF025) begin
                stop = 1'b1; m_cause = 2'd3;
            end else if (hit >= 0 && !m_skip) begin
                stop = 1'b1; m_cause = 2'd2; m_hit = 2'(hit);
            end else if (m_step_mode && m_left == 1) begin
                stop = 1'b1; m_cause = 2'd2;
            end else if (m_drain) begin
                stop = 1'b1; m_cause = 2'd1;
            end
            m_count++;
            m_skip = 1'b0;
            if (m_step_mode) m_left--;
        end
        if (cmd_valid && cmd_op == 2'd0) m_count = 16'd0;
        if (stop) begin
            m_halted = 1'b1; m_step_mode = 1'b0; m_drain = 1'b0;
        end else if (cmd_valid) begin
            case (cmd_op)
                2'd1: if (m_halted) begin
                          m_halted = 1'b0; m_step_mode = 1'b0; m_skip = 1'b1;
                      end else m_err = 1'b1;
                2'd3: if (m_halted) begin
                          m_halted = 1'b0; m_step_mode = 1'b1; m_skip = 1'b1;
                          m_left = (cmd_count == 8'd0) ? 1 : int'(cmd_count);
                      end else m_err = 1'b1;
                2'd2: if (!m_halted && !m_drain) begin
                          m_drain = 1'b1; m_step_mode = 1'b0;
                      end else m_err = 1'b1;
                default: ;
            endcase
        end
        if (bp_wr_en) begin
            m_bp_v[bp_wr_idx] = bp_wr_valid;
            m_bp_a[bp_wr_idx] = bp_wr_addr;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic idle();
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 8'd0;
        instr_retire = 1'b0; ir = 16'h1000; pc_next = 16'h0000;
        bp_wr_en = 1'b0; bp_wr_idx = 2'd0; bp_wr_addr = 16'd0; bp_wr_valid = 1'b0;
    endtask

    task automatic command(input logic [1:0] op, input logic [7:0] n);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = n;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        checks += 4;
        if (cpu_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_cpu_en: got %b expected 1", cpu_en); end
        if (halt_cause !== 2'd0) begin errors++; $display("[TB] FAIL reset_cause: got %0d expected 0", halt_cause); end
        if (retire_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %h expected 0000", retire_count); end
        if (cmd_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_err: got %b expected 0", cmd_err); end
    endtask

    task automatic test_run_retire();
        instr_retire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_next = 16'h3000 + 16'(i);
            tick();
            checks++;
            if (cpu_en !== 1'b1) begin errors++; $display("[TB] FAIL run_cpu_en[%0d]: got %b expected 1", i, cpu_en); end
        end
        instr_retire = 1'b0;
        checks += 2;
        if (retire_count !== 16'd3) begin errors++; $display("[TB] FAIL run_count: got %0d expected 3", retire_count); end
        if (halt_cause !== 2'd0) begin errors++; $display("[TB] FAIL run_cause: got %0d expected 0", halt_cause); end
    endtask

    task automatic test_host_halt();
        command(2'd2, 8'd0);
        checks++;
        if (cpu_en !== 1'b1) begin errors++; $display("[TB] FAIL drain_cpu_en0: got %b expected 1", cpu_en); end
        tick();
        checks++;
        if (cpu_en !== 1'b1) begin errors++; $display("[TB] FAIL drain_cpu_en1: got %b expected 1", cpu_en); end
        instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        checks += 3;
        if (cpu_en !== 1'b0) begin errors++; $display("[TB] FAIL host_halt_cpu_en: got %b expected 0", cpu_en); end
        if (halted !== 1'b1) begin errors++; $display("[TB] FAIL host_halt_halted: got %b expected 1", halted); end
        if (halt_cause !== 2'd1) begin errors++; $display("[TB] FAIL host_halt_cause: got %0d expected 1", halt_cause); end
    endtask

    task automatic test_step();
        int counts [2] = '{0, 5};
        int expected;
        int retired;
        for (int t = 0; t < 2; t++) begin
            expected = (counts[t] == 0) ? 1 : counts[t];
            command(2'd3, 8'(counts[t]));
            instr_retire = 1'b1;
            retired = 0;
            for (int k = 0; k < 20 && cpu_en; k++) begin
                pc_next = 16'h3100 + 16'(k);
                tick();
                retired++;
            end
            instr_retire = 1'b0;
            checks += 3;
            if (retired !== expected) begin errors++; $display("[TB] FAIL step_retires(n=%0d): got %0d expected %0d", counts[t], retired, expected); end
            if (halted !== 1'b1) begin errors++; $display("[TB] FAIL step_halted(n=%0d): got %b expected 1", counts[t], halted); end
            if (halt_cause !== 2'd2) begin errors++; $display("[TB] FAIL step_cause(n=%0d): got %0d expected 2", counts[t], halt_cause); end
        end
    endtask

    task automatic test_breakpoint();
        bp_wr_en = 1'b1; bp_wr_idx = 2'd2; bp_wr_addr = 16'h3005; bp_wr_valid = 1'b1;
        tick();
        bp_wr_en = 1'b0;
        command(2'd1, 8'd0);
        instr_retire = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_next = 16'h3000 + 16'($urandom_range(0, 4));
            tick();
            checks++;
            if (cpu_en !== 1'b1) begin errors++; $display("[TB] FAIL bp_no_match[%0d]: got cpu_en %b expected 1", i, cpu_en); end
        end
        pc_next = 16'h3005;
        tick();
        instr_retire = 1'b0;
        checks += 3;
        if (halted !== 1'b1) begin errors++; $display("[TB] FAIL bp_halted: got %b expected 1", halted); end
        if (bp_hit_idx !== 2'd2) begin errors++; $display("[TB] FAIL bp_hit_idx: got %0d expected 2", bp_hit_idx); end
        if (halt_cause !== 2'd2) begin errors++; $display("[TB] FAIL bp_cause: got %0d expected 2", halt_cause); end
        command(2'd1, 8'd0);
        instr_retire = 1'b1;
        pc_next = 16'h3005;
        tick();
        checks++;
        if (cpu_en !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume_skip: got cpu_en %b expected 1", cpu_en); end
        pc_next = 16'h3001;
        tick();
        pc_next = 16'h3005;
        tick();
        instr_retire = 1'b0;
        checks += 2;
        if (halted !== 1'b1) begin errors++; $display("[TB] FAIL bp_rehit_halted: got %b expected 1", halted); end
        if (bp_hit_idx !== 2'd2) begin errors++; $display("[TB] FAIL bp_rehit_idx: got %0d expected 2", bp_hit_idx); end
    endtask

    task automatic test_trap_priority();
        command(2'd1, 8'd0);
        instr_retire = 1'b1;
        pc_next = 16'h3001;
        tick();
        ir = 16'hF025;
        pc_next = 16'h3005;
        tick();
        instr_retire = 1'b0;
        ir = 16'h1000;
        checks += 2;
        if (halted !== 1'b1) begin errors++; $display("[TB] FAIL trap_halted: got %b expected 1", halted); end
        if (halt_cause !== 2'd3) begin errors++; $display("[TB] FAIL trap_cause: got %0d expected 3", halt_cause); end
    endtask

    task automatic test_cmd_err();
        command(2'd1, 8'd0);
        checks++;
        if (cmd_err !== 1'b0) begin errors++; $display("[TB] FAIL err_legal_run: got %b expected 0", cmd_err); end
        command(2'd3, 8'd1);
        checks += 2;
        if (cmd_err !== 1'b1) begin errors++; $display("[TB] FAIL err_pulse: got %b expected 1", cmd_err); end
        if (cpu_en !== 1'b1) begin errors++; $display("[TB] FAIL err_cpu_en: got %b expected 1", cpu_en); end
        tick();
        checks++;
        if (cmd_err !== 1'b0) begin errors++; $display("[TB] FAIL err_one_cycle: got %b expected 0", cmd_err); end
        instr_retire = 1'b1;
        pc_next = 16'h3000;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (cpu_en !== 1'b1) begin errors++; $display("[TB] FAIL err_still_running[%0d]: got %b expected 1", i, cpu_en); end
        end
        instr_retire = 1'b0;
    endtask

    task automatic test_clr_cnt();
        instr_retire = 1'b1;
        pc_next = 16'h3000;
        command(2'd0, 8'd0);
        checks++;
        if (retire_count !== 16'd0) begin errors++; $display("[TB] FAIL clr_with_retire: got %h expected 0000", retire_count); end
        tick();
        instr_retire = 1'b0;
        checks++;
        if (retire_count !== 16'd1) begin errors++; $display("[TB] FAIL clr_then_retire: got %h expected 0001", retire_count); end
    endtask

    task automatic test_wrap();
        bp_wr_en = 1'b1; bp_wr_idx = 2'd2; bp_wr_addr = 16'h3005; bp_wr_valid = 1'b0;
        command(2'd0, 8'd0);
        bp_wr_en = 1'b0;
        instr_retire = 1'b1;
        pc_next = 16'h4000;
        repeat (65535) tick();
        checks++;
        if (retire_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preset: got %h expected ffff", retire_count); end
        tick();
        instr_retire = 1'b0;
        checks += 2;
        if (retire_count !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected 0000", retire_count); end
        if (cpu_en !== 1'b1) begin errors++; $display("[TB] FAIL wrap_cpu_en: got %b expected 1", cpu_en); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            cmd_valid    = ($urandom_range(0, 4) == 0);
            cmd_op       = 2'($urandom_range(0, 3));
            cmd_count    = 8'($urandom_range(0, 6));
            instr_retire = ($urandom_range(0, 2) != 0);
            ir           = ($urandom_range(0, 24) == 0) ? 16'hF025 : 16'($urandom_range(0, 16'hEFFF));
            pc_next      = 16'h3000 + 16'($urandom_range(0, 7));
            bp_wr_en     = ($urandom_range(0, 15) == 0);
            bp_wr_idx    = 2'($urandom_range(0, 3));
            bp_wr_addr   = 16'h3000 + 16'($urandom_range(0, 7));
            bp_wr_valid  = 1'($urandom_range(0, 1));
            tick();
            checks += 6;
            if (cpu_en !== !m_halted) begin errors++; $display("[TB] FAIL rand_cpu_en@%0d: got %b expected %b", c, cpu_en, !m_halted); end
            if (halted !== m_halted) begin errors++; $display("[TB] FAIL rand_halted@%0d: got %b expected %b", c, halted, m_halted); end
            if (halt_cause !== m_cause) begin errors++; $display("[TB] FAIL rand_cause@%0d: got %0d expected %0d", c, halt_cause, m_cause); end
            if (bp_hit_idx !== m_hit) begin errors++; $display("[TB] FAIL rand_bp_idx@%0d: got %0d expected %0d", c, bp_hit_idx, m_hit); end
            if (cmd_err !== m_err) begin errors++; $display("[TB] FAIL rand_cmd_err@%0d: got %b expected %b", c, cmd_err, m_err); end
            if (retire_count !== m_count) begin errors++; $display("[TB] FAIL rand_count@%0d: got %h expected %h", c, retire_count, m_count); end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_run_retire();
        test_host_halt();
        test_step();
        test_breakpoint();
        test_trap_priority();
        test_cmd_err();
        test_clr_cnt();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/punc_run_control.md
Name: punc_run_control

Overview:
- Run/halt/step sequencer for the PUnC LC3 core; sits between the host/debug interface and the core's control FSM.
- Gates core progress with a clock-enable (cpu_en) and halts only at instruction boundaries.
- Halts the core on host command, on a completed step count, on a PC breakpoint match, or when the core retires TRAP x25 (HALT).
- Keeps a retired-instruction counter for debug.

Parameters:
- NUM_BP, 4, number of PC breakpoint registers.
- BP_IDX_W, 2, width of breakpoint index; must equal clog2(NUM_BP).
- CNT_W, 8, width of the step-count field.
- START_RUNNING, 1, 1 = core runs out of reset; 0 = core is held halted out of reset.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- cmd_valid, input, 1, single-cycle host command strobe.
- cmd_op, input, 2, 00 CLR_CNT, 01 RUN, 10 HALT, 11 STEP.
- cmd_count, input, CNT_W, number of instructions for STEP; 0 is treated as 1.
- instr_retire, input, 1, core control FSM is in the final cycle of an instruction; only meaningful while cpu_en=1.
- ir, input, 16, instruction register of the retiring instruction.
- pc_next, input, 16, address of the next instruction; valid when instr_retire=1.
- bp_wr_en, input, 1, breakpoint table write strobe.
- bp_wr_idx, input, BP_IDX_W, breakpoint entry to write.
- bp_wr_addr, input, 16, breakpoint address.
- bp_wr_valid, input, 1, enable bit written to the entry.
- cpu_en, output, 1, core may advance this cycle.
- halted, output, 1, core is stopped.
- halt_cause, output, 2, 00 RESET, 01 HOST, 10 BP/STEP, 11 TRAP.
- bp_hit_idx, output, BP_IDX_W, lowest matching breakpoint index of the last BP halt.
- cmd_err, output, 1, one-cycle pulse when a command is illegal in the current state.
- retire_count, output, 16, count of retired instructions.

Behaviour:
- States: HALTED, RUNNING, STEPPING, DRAIN.
- cpu_en = (state != HALTED), driven from the registered state. halted = ~cpu_en.
- A retire "counts" only when instr_retire=1 and cpu_en=1.
- Reset:
  - state = RUNNING if START_RUNNING else HALTED.
  - halt_cause = 00, bp_hit_idx = 0, cmd_err = 0, retire_count = 0, step counter = 0.
  - All breakpoint valid bits = 0.
  - skip_bp = 0.
  - Reset mid-instruction aborts everything; there is no drain.
- Halt conditions, evaluated on a counting retire, in priority order:
  - TRAP: ir == 16'hF025.
  - BP: some valid entry has addr == pc_next and skip_bp == 0.
  - STEP-done: state is STEPPING and remaining == 1.
  - HOST: state is DRAIN.
- When any halt condition fires, next state is HALTED and halt_cause is set accordingly (BP and STEP-done both report 10). On BP, bp_hit_idx is set to the lowest matching index.
- Transitions:
  - HALTED + RUN -> RUNNING; skip_bp := 1.
  - HALTED + STEP(n) -> STEPPING; remaining := max(n,1); skip_bp := 1.
  - RUNNING or STEPPING + HALT -> DRAIN.
  - STEPPING: each counting retire decrements remaining.
  - DRAIN: cpu_en stays 1 until the next retire, then the core goes to HALTED.
  - Any counting retire clears skip_bp. This guarantees resuming from a breakpoint address executes at least one instruction.
- Illegal commands pulse cmd_err for 1 cycle with no state change:
  - RUN or STEP while not HALTED.
  - HALT while HALTED or DRAIN.
- CLR_CNT is legal in every state and sets retire_count to 0. If a counting retire happens in the same cycle, the result is 0 (clear wins).
- Latency:
  - A command is sampled at a clock edge; the new cpu_en is visible the following cycle.
  - A halting retire gives cpu_en=0 on the next cycle.
- retire_count increments on every counting retire and wraps from FFFF to 0000.
- Breakpoint table:
  - Writes take effect at the clock edge.
  - A same-cycle retire compares against the pre-write table.
- A command and a halting retire in the same cycle: the retire's halt is taken, and the command is evaluated against the resulting HALTED state on the next cmd_valid only (i.e. it is dropped). cmd_err is not pulsed in this case.

Test Plan:
- Reset with START_RUNNING=1, retire 3 instructions -> cpu_en=1 throughout, retire_count=3, halt_cause=00.
- While RUNNING, HALT issued mid-instruction -> cpu_en stays 1 until the next retire, then 0; halt_cause=01.
- STEP with count=0, then STEP with count=5 -> exactly 1 retire, then exactly 5 retires, each ending with halt_cause=10.
- Breakpoint 2 set to x3005, run until pc_next=x3005 -> halted, bp_hit_idx=2. Then RUN -> first retire does not re-halt; a later hit at x3005 halts again.
- Retire with ir=F025 while pc_next also matches a breakpoint -> halt_cause=11 (TRAP priority).
- STEP issued while RUNNING -> cmd_err pulses 1 cycle, state unchanged. CLR_CNT coincident with a retire -> retire_count=0. Counter preset to FFFF by retires -> wraps to 0000.
